// File: rtl/lstm_fx_pkg.sv
// Q4.13 fixed-point definitions shared by the LSTM cell-state, tanh and hidden-multiply stages.
package lstm_fx_pkg;

    localparam int unsigned BITWIDTH = 18;
    localparam int unsigned FRAC     = 13;
    localparam int unsigned PROD_W   = 2 * BITWIDTH;
    localparam int unsigned SUM_W    = PROD_W + 1;
    localparam int          SAT_MAX  = 131071;
    localparam int          SAT_MIN  = -131072;

    typedef struct packed {
        logic signed [BITWIDTH-1:0] val;
        logic                       ovf;
    } fx_sat_t;

    function automatic fx_sat_t fx_sat(input logic signed [SUM_W-1:0] x);
        fx_sat_t r;
        if (x > SUM_W'(SAT_MAX)) begin
            r.val = BITWIDTH'(SAT_MAX);
            r.ovf = 1'b1;
        end else if (x < SUM_W'(SAT_MIN)) begin
            r.val = BITWIDTH'(SAT_MIN);
            r.ovf = 1'b1;
        end else begin
            r.val = x[BITWIDTH-1:0];
            r.ovf = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/fx_mac2_sat.sv
// Combinational sum of two Q8.26 products, rescaled to Q4.13 (floor) and saturated to 18 bits.
module fx_mac2_sat
    import lstm_fx_pkg::*;
(
    input  logic signed [PROD_W-1:0]   p_f_i,
    input  logic signed [PROD_W-1:0]   p_i_i,
    output logic signed [BITWIDTH-1:0] c_o,
    output logic                       sat_o
);

    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] shifted;
    fx_sat_t                 res;

    always_comb begin
        sum     = SUM_W'(p_f_i) + SUM_W'(p_i_i);
        shifted = sum >>> FRAC;
        res     = fx_sat(shifted);
        c_o     = res.val;
        sat_o   = res.ovf;
    end

endmodule

// File: rtl/lstm_cell_state.sv
// Streaming LSTM cell-state update c_t = f*c_{t-1} + i*g with per-element state memory.
// Optional saturation counter enabled by defining LSTM_CELL_SATCNT_EN.
module lstm_cell_state
    import lstm_fx_pkg::*;
#(
    parameter int unsigned NUM_CELLS = 32,
    parameter int unsigned IDX_W     = $clog2(NUM_CELLS)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic signed [BITWIDTH-1:0] f_gate_i,
    input  logic signed [BITWIDTH-1:0] i_gate_i,
    input  logic signed [BITWIDTH-1:0] g_in_i,
    input  logic                       clear_state_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic signed [BITWIDTH-1:0] c_out_o,
    output logic [IDX_W-1:0]           c_idx_o,
    output logic                       c_last_o,
    output logic [15:0]                sat_count_o
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_CELLS - 1);

    logic [IDX_W-1:0]           idx_q, idx_d;
    logic                       zero_prev_q, zero_prev_d;
    logic                       pend_q, pend_d;
    logic                       s1_valid_q;
    logic signed [PROD_W-1:0]   s1_pf_q, s1_pi_q;
    logic [IDX_W-1:0]           s1_idx_q;
    logic                       out_valid_q;
    logic signed [BITWIDTH-1:0] c_out_q;
    logic [IDX_W-1:0]           c_idx_q;
    logic                       c_last_q;
    logic signed [BITWIDTH-1:0] mem_q [NUM_CELLS];

    logic                       advance, accept, s2_load, zero_eff;
    logic signed [BITWIDTH-1:0] c_old;
    logic signed [PROD_W-1:0]   p_f, p_i;
    logic signed [BITWIDTH-1:0] mac_c;
    logic                       mac_sat;

    assign advance = !out_valid_q || out_ready_i;
    assign accept  = in_valid_i && advance;
    assign s2_load = advance && s1_valid_q;

    // A clear arriving with element 0 already applies to that element.
    assign zero_eff = zero_prev_q || (clear_state_i && idx_q == '0);
    assign c_old    = zero_eff ? '0 : mem_q[idx_q];
    assign p_f      = PROD_W'(f_gate_i) * PROD_W'(c_old);
    assign p_i      = PROD_W'(i_gate_i) * PROD_W'(g_in_i);

    always_comb begin
        idx_d       = idx_q;
        zero_prev_d = zero_prev_q;
        pend_d      = pend_q;
        if (accept) begin
            if (idx_q == LastIdx) begin
                idx_d       = '0;
                zero_prev_d = pend_q || clear_state_i;
                pend_d      = 1'b0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
                if (clear_state_i) begin
                    if (idx_q == '0) begin
                        zero_prev_d = 1'b1;
                    end else begin
                        pend_d = 1'b1;
                    end
                end
            end
        end
    end

    fx_mac2_sat u_mac (
        .p_f_i (s1_pf_q),
        .p_i_i (s1_pi_q),
        .c_o   (mac_c),
        .sat_o (mac_sat)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q       <= '0;
            zero_prev_q <= 1'b1;
            pend_q      <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_pf_q     <= '0;
            s1_pi_q     <= '0;
            s1_idx_q    <= '0;
            out_valid_q <= 1'b0;
            c_out_q     <= '0;
            c_idx_q     <= '0;
            c_last_q    <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            zero_prev_q <= zero_prev_d;
            pend_q      <= pend_d;
            if (advance) begin
                s1_valid_q  <= accept;
                out_valid_q <= s1_valid_q;
                if (accept) begin
                    s1_pf_q  <= p_f;
                    s1_pi_q  <= p_i;
                    s1_idx_q <= idx_q;
                end
                if (s1_valid_q) begin
                    c_out_q  <= mac_c;
                    c_idx_q  <= s1_idx_q;
                    c_last_q <= (s1_idx_q == LastIdx);
                end
            end
        end
    end

    // State memory is deliberately not reset; zero_prev masks it after reset.
    always_ff @(posedge clk_i) begin
        if (s2_load) begin
            mem_q[s1_idx_q] <= mac_c;
        end
    end

`ifdef LSTM_CELL_SATCNT_EN
    logic [15:0] sat_count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sat_count_q <= '0;
        end else if (s2_load && mac_sat && sat_count_q != 16'hFFFF) begin
            sat_count_q <= sat_count_q + 16'd1;
        end
    end

    assign sat_count_o = sat_count_q;
`else
    logic unused_sat;
    assign unused_sat  = mac_sat;
    assign sat_count_o = '0;
`endif

    assign in_ready_o  = advance;
    assign out_valid_o = out_valid_q;
    assign c_out_o     = c_out_q;
    assign c_idx_o     = c_idx_q;
    assign c_last_o    = c_last_q;

endmodule

// File: tb/tb_lstm_cell_state.sv
// Scoreboard bench for lstm_cell_state: a behavioural model predicts each c_t at acceptance.
module tb_lstm_cell_state;

    localparam int N  = 4;
    localparam int IW = $clog2(N);
`ifdef LSTM_CELL_SATCNT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [17:0]  f_gate = '0, i_gate = '0, g_in = '0;
    logic                clear_state = 1'b0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic signed [17:0]  c_out;
    logic [IW-1:0]       c_idx;
    logic                c_last;
    logic [15:0]         sat_count;

    always #5 clk = ~clk;

    lstm_cell_state #(.NUM_CELLS(N)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .f_gate_i      (f_gate),
        .i_gate_i      (i_gate),
        .g_in_i        (g_in),
        .clear_state_i (clear_state),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .c_out_o       (c_out),
        .c_idx_o       (c_idx),
        .c_last_o      (c_last),
        .sat_count_o   (sat_count)
    );

    typedef struct {
        int c;
        int idx;
        int last;
        int sat;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    // Reference model state: stored c per element, vector position, clear bookkeeping.
    int   m_mem[N];
    int   m_idx = 0;
    bit   m_zero = 1'b1;
    bit   m_pend = 1'b0;
    int   m_sat = 0;

    int   rmode = 0;      // 0: always ready, 1: random ready, 2: ready held low
    int   hold_left = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rnd_full();
        logic signed [17:0] r;
        r = 18'($urandom);
        return int'(r);
    endfunction

    task automatic model_accept(input int f, input int i, input int g, input bit clr);
        exp_t   e;
        longint sum, sh;
        int     cold, res;
        bit     zero;
        zero = m_zero || (clr && m_idx == 0);
        cold = zero ? 0 : m_mem[m_idx];
        sum  = longint'(f) * longint'(cold) + longint'(i) * longint'(g);
        sh   = sum >>> 13;
        if (sh > 131071) res = 131071;
        else if (sh < -131072) res = -131072;
        else res = int'(sh);
        if ((sh > 131071 || sh < -131072) && m_sat < 65535) m_sat++;
        m_mem[m_idx] = res;
        e.c    = res;
        e.idx  = m_idx;
        e.last = (m_idx == N - 1) ? 1 : 0;
        e.sat  = SAT_EN ? m_sat : 0;
        q.push_back(e);
        if (clr && m_idx == 0) m_zero = 1'b1;
        else if (clr) m_pend = 1'b1;
        if (m_idx == N - 1) begin
            m_idx  = 0;
            m_zero = m_pend;
            m_pend = 1'b0;
        end else begin
            m_idx++;
        end
    endtask

    task automatic step(input bit v, input int f, input int i, input int g, input bit clr,
                        output bit acc);
        @(negedge clk);
        if (hold_left > 0) begin
            out_ready = 1'b0;
            hold_left--;
        end else if (rmode == 1) out_ready = ($urandom_range(0, 3) != 0);
        else if (rmode == 2) out_ready = 1'b0;
        else out_ready = 1'b1;
        in_valid    = v;
        f_gate      = 18'(f);
        i_gate      = 18'(i);
        g_in        = 18'(g);
        clear_state = clr;
        #1;
        acc = v && in_ready;
        if (acc) model_accept(f, i, g, clr);
    endtask

    task automatic send(input int f, input int i, input int g, input bit clr);
        bit acc;
        int tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 100) begin
            step(1'b1, f, i, g, clr, acc);
            tries++;
        end
        if (!acc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", tries);
        end
    endtask

    task automatic drain();
        bit acc;
        int t;
        t = 0;
        while (q.size() != 0 && t < 300) begin
            step(1'b0, 0, 0, 0, 1'b0, acc);
            t++;
        end
        step(1'b0, 0, 0, 0, 1'b0, acc);
        step(1'b0, 0, 0, 0, 1'b0, acc);
        check("drain_queue_empty", q.size(), 0);
    endtask

    // Monitor: pops the scoreboard on every transfer and checks stall behaviour.
    initial begin : monitor
        exp_t e;
        bit   held;
        int   h_c, h_idx, h_last;
        held = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (!out_valid) check("in_ready_when_empty", int'(in_ready), 1);
                if (out_valid && !out_ready) check("in_ready_when_stalled", int'(in_ready), 0);
                if (held) begin
                    check("hold_out_valid", int'(out_valid), 1);
                    check("hold_c_out", int'(c_out), h_c);
                    check("hold_c_idx", int'(c_idx), h_idx);
                    check("hold_c_last", int'(c_last), h_last);
                end
                held = out_valid && !out_ready;
                if (held) begin
                    h_c    = int'(c_out);
                    h_idx  = int'(c_idx);
                    h_last = int'(c_last);
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_output: got c_out=%0d c_idx=%0d expected none",
                                 c_out, c_idx);
                    end else begin
                        e = q.pop_front();
                        check("c_out", int'(c_out), e.c);
                        check("c_idx", int'(c_idx), e.idx);
                        check("c_last", int'(c_last), e.last);
                        check("sat_count", int'(sat_count), e.sat);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no finish expected completion within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit acc;
        int f, i, g;
        bit clr;

        repeat (2) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_c_out", int'(c_out), 0);
        check("rst_c_idx", int'(c_idx), 0);
        check("rst_c_last", int'(c_last), 0);
        check("rst_sat_count", int'(sat_count), 0);
        check("rst_in_ready", int'(in_ready), 1);
        #3 rst_n = 1'b1;

        // Directed vectors: plain update, state read-back with pending clear, saturation.
        rmode = 0;
        for (int k = 0; k < N; k++) send(8192, 8192, 4096, k == 0);
        for (int k = 0; k < N; k++) send(4096, 0, 8192, k == 1);
        for (int k = 0; k < N; k++) send(8192, 131071, 131071, 1'b0);
        for (int k = 0; k < N; k++) send(0, 131071, -131072, 1'b0);
        drain();

        // Backpressure mid-stream.
        for (int k = 0; k < N; k++) begin
            if (k == 2) hold_left = 3;
            send(8192, 8192, 4096, 1'b0);
        end
        drain();

        // Clear raised mid-vector takes effect on the following vector.
        for (int k = 0; k < N; k++) send(8192, 8192, 4096, k == 2);
        for (int k = 0; k < N; k++) send(8192, 0, 1234, 1'b0);
        drain();

        // Asynchronous reset with both pipeline stages full.
        rmode = 2;
        step(1'b1, 8192, 8192, 4096, 1'b0, acc);
        step(1'b1, 8192, 8192, 4096, 1'b0, acc);
        @(negedge clk);
        in_valid = 1'b0;
        #3;
        check("pre_reset_out_valid", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_c_idx", int'(c_idx), 0);
        check("reset_sat_count", int'(sat_count), 0);
        q.delete();
        m_idx  = 0;
        m_zero = 1'b1;
        m_pend = 1'b0;
        m_sat  = 0;
        @(negedge clk);
        #3 rst_n = 1'b1;
        rmode = 0;
        for (int k = 0; k < N; k++) send(8192, 0, 5000, 1'b0);
        for (int k = 0; k < N; k++) send(8192, 8192, 8192, 1'b0);
        drain();

        // Randomized traffic with bubbles, random backpressure and mid-vector clears.
        rmode = 1;
        for (int n = 0; n < 160; n++) begin
            if ($urandom_range(0, 4) == 0) step(1'b0, 0, 0, 0, 1'b0, acc);
            if ($urandom_range(0, 7) == 0) begin
                f = rnd_full();
                i = rnd_full();
                g = rnd_full();
            end else begin
                f = int'($urandom_range(0, 12000));
                i = int'($urandom_range(0, 12000));
                g = int'($urandom_range(0, 200000)) - 100000;
            end
            clr = (m_idx != 0) && ($urandom_range(0, 7) == 0);
            send(f, i, g, clr);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lstm_cell_state.md
# lstm_cell_state

Computes the LSTM cell-state update c_t = f ⊙ c_{t-1} + i ⊙ g, one element per beat, over a vector of NUM_CELLS elements. Holds c_{t-1} for every element in an internal state memory and saturates each result to the 18-bit fixed-point format. The c_t stream feeds the tanh stage directly upstream of the hidden-state multiply. The block is pipelined and streaming, with valid/ready handshakes on both sides.

## Interface
- BITWIDTH, 18, signed word width shared with tanh
- FRAC, 13, fractional bits (1.0 = 8192; range [-16, 16))
- NUM_CELLS, 32, elements per vector; legal range 4..1024
- IDX_W, $clog2(NUM_CELLS), element index width
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- in_valid  in  1  gate triple valid
- in_ready  out  1  block accepts triple this cycle
- f_gate  in  BITWIDTH  forget gate, signed Q4.13
- i_gate  in  BITWIDTH  input gate, signed Q4.13
- g_in  in  BITWIDTH  candidate value, signed Q4.13
- clear_state  in  1  level; next vector starts from c_{t-1}=0
- out_valid  out  1  c_out valid
- out_ready  in  1  downstream (tanh) accepts
- c_out  out  BITWIDTH  saturated c_t
- c_idx  out  IDX_W  element index of c_out
- c_last  out  1  c_out is element NUM_CELLS-1
- sat_count  out  16  saturation event count

## Operation
- **Reset values:** out_valid=0, c_out=0, c_idx=0, c_last=0, sat_count=0. The internal index idx=0 and zero_prev=1. The state memory is not reset.
- **Handshake:** a triple is accepted when in_valid && in_ready.
  - Each acceptance uses element idx. idx then wraps from NUM_CELLS-1 to 0.
- **Stage 1 (S1):**
  - Registers the products p_f = f_gate*c_old and p_i = i_gate*g_in, each 36-bit signed.
  - c_old = 0 if zero_prev, otherwise mem[idx] (asynchronous read).
- **Stage 2 (S2):**
  - sum = p_f + p_i at 37 bits.
  - Arithmetic shift right by FRAC (truncation toward −inf).
  - Saturate to [-131072, 131071].
  - Register the result into c_out and write it to mem[idx] on the same edge.
- **zero_prev:**
  - Set when clear_state is sampled high while idx==0 on an acceptance edge, or when a pending clear exists.
  - clear_state sampled high mid-vector (idx≠0) latches a pending flag. The pending flag takes effect at the next wrap to 0.
  - zero_prev itself clears on the wrap after element NUM_CELLS-1.
- **Saturation events:** a saturation event occurs when the shifted sum lies outside the range. sat_count increments once per saturated output and holds at 65535.
- **Hazard freedom:** element k is written 2 edges after acceptance and re-read no earlier than NUM_CELLS ≥ 4 acceptances later, so no bypass is needed.

## Timing
- Latency: a triple accepted at edge t appears with out_valid=1 after edge t+2.
- Throughput: 1 element/cycle.
- advance = !s2_valid || out_ready; in_ready = advance (combinational).
- While out_valid && !out_ready:
  - S1 and S2 hold.
  - c_out, c_idx and c_last are stable.
  - No memory write repeats.
  - idx does not advance.
- A bubble (in_valid=0 with advance=1) propagates as s1_valid=0 and causes no write.
- out_valid may rise with out_ready low; it drops only after a transfer with no new S1 data.
- Reset mid-operation:
  - All pipeline contents are discarded immediately (asynchronous).
  - The first vector after reset uses c_old=0.
- clear_state is sampled only on acceptance edges; it is ignored when in_valid=0.

## Configuration
- LSTM_CELL_SATCNT_EN:
  - Defined: sat_count is implemented as described.
  - Undefined: sat_count is constant 0 and no counter logic is synthesised. The datapath saturation still occurs.

## Structure
- Package lstm_fx_pkg holds:
  - BITWIDTH and FRAC
  - SAT_MAX = 131071 and SAT_MIN = -131072
  - function fx_sat(37-bit) -> 18-bit, with an overflow flag
- The same package is shared with the tanh and hidden-multiply stages.
- One sub-module, fx_mac2_sat: the combinational sum, shift and saturate of the two products, used in S2.
- Top level contains: the handshake, idx/zero_prev/pending control, the state memory and the S1/S2 registers.

## Test plan
- **First vector:** NUM_CELLS=4, reset, clear, then 4 triples f=8192, i=8192, g=4096 -> c_out=4096 ×4, c_idx 0..3, c_last only at idx 3, sat_count=0.
- **Second vector:** next vector f=4096, i=0, g=8192 -> c_out=2048 ×4, proving state read-back.
- **Saturation:** i=g=131071 with zero state -> c_out=131071 and sat_count +1 each. Then i=131071, g=-131072 -> c_out=-131072.
- **Backpressure:** out_ready=0 for 3 cycles mid-stream -> in_ready=0, c_out/c_idx held, and all 4 elements are delivered exactly once in order.
- **Mid-vector clear:** clear_state high at idx 2 -> elements 2,3 still use stored c; the next vector with f=8192, i=0 outputs 0 ×4.
- **Reset mid-operation:** reset pulsed with S2 full -> out_valid=0 at once. The next vector with f=8192, i=0 outputs 0, and c_idx restarts at 0.
